pad_input_filter: RTL and testbench

- Conditioning stage directly downstream of the bidirectional pad cell.
- Consumes the pad cell's asynchronous input value (`pad_out_o` of the pad).
- Synchronizes it into `clk_i`, optionally debounces it with a programmable stability window, and produces:
  - a clean level,
  - one-cycle rise/fall pulses,
  - a sticky, edge-selectable event flag for GPIO/interrupt logic.
- One instance per input-capable pad.

---
 rtl/pad_input_filter.sv | 113 +++++++++++
 tb/tb_pad_input_filter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pad_input_filter.sv
// pad_input_filter: synchronizes an asynchronous pad input into clk_i,
// optionally debounces it over a programmable stability window, and
// produces a clean level, one-cycle rise/fall pulses and a sticky event flag.
module pad_input_filter #(
    parameter int   SYNC_STAGES = 2,      // 2..4 flops in the synchronizer
    parameter int   CNT_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_in_async_i,
    input  logic             filter_en_i,
    input  logic [CNT_W-1:0] debounce_cycles_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             event_clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             event_o
);

    typedef enum logic {STABLE, COUNTING} state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       n_eff;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   level_d;
    logic                   mismatch;
    logic                   event_set;

    // Plain flop chain, no logic between stages, so metastability resolves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_ff <= {SYNC_STAGES{RESET_VAL}};
        else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], pad_in_async_i};
    end

    assign sync_q   = sync_ff[SYNC_STAGES-1];
    assign mismatch = (sync_q != level_o);
    // Bypass or a zero window both mean "accept on the first mismatching cycle".
    assign n_eff    = (!filter_en_i || (debounce_cycles_i == '0)) ? CNT_W'(1) : debounce_cycles_i;
    // Counter never exceeds n_eff-1 <= 2^CNT_W-2, so the increment cannot wrap.
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // State, counter and level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_o <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_o <= level_d;
        end
    end

    // Next-state logic. A ">=" compare lets a lowered threshold take effect
    // immediately when the count already meets it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_o;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (n_eff == CNT_W'(1)) begin
                        level_d = sync_q;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (!mismatch) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_inc >= n_eff) begin
                    level_d = sync_q;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    assign event_set = (rise_o && edge_sel_i[0]) || (fall_o && edge_sel_i[1]);

    // Edge pulses line up with the first cycle level_o shows the new value;
    // the event flag follows one cycle later and a set beats a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            event_o <= 1'b0;
        end else begin
            rise_o  <= level_d & ~level_o;
            fall_o  <= ~level_d & level_o;
            event_o <= event_set | (event_o & ~event_clr_i);
        end
    end

endmodule

// File: tb/tb_pad_input_filter.sv
// Directed bench for pad_input_filter with a behavioural reference model
// checked every cycle, plus literal expectations at key points.
module tb_pad_input_filter;

    localparam int SYNC = 2;
    localparam int CW   = 16;

    logic          clk = 0;
    logic          rst = 1;
    logic          pad = 1;
    logic          fen = 0;
    logic [CW-1:0] dbc = 16'd5;
    logic [1:0]    es  = 2'b00;
    logic          clr = 0;
    logic          level, rise, fall, evt;

    int checks = 0;
    int fails  = 0;

    pad_input_filter #(.SYNC_STAGES(SYNC), .CNT_W(CW), .RESET_VAL(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .pad_in_async_i(pad), .filter_en_i(fen),
        .debounce_cycles_i(dbc), .edge_sel_i(es), .event_clr_i(clr),
        .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(evt)
    );

    always #5 clk = ~clk;

    // Reference model: pad delayed SYNC cycles; level flips once the run of
    // consecutive disagreeing cycles reaches the effective threshold.
    logic m_sync [SYNC];
    logic m_level, m_rise, m_fall, m_event;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] <= 1'b0;
            m_level <= 0; m_rise <= 0; m_fall <= 0; m_event <= 0; m_run <= 0;
        end else begin
            automatic logic sq   = m_sync[SYNC-1];
            automatic int   neff = (!fen || dbc == 0) ? 1 : int'(dbc);
            automatic int   run  = (sq != m_level) ? m_run + 1 : 0;
            automatic logic flip = (sq != m_level) && (run >= neff);
            m_event <= ((m_rise && es[0]) || (m_fall && es[1])) ? 1'b1 : (clr ? 1'b0 : m_event);
            m_rise  <= flip && sq;
            m_fall  <= flip && !sq;
            if (flip) m_level <= sq;
            m_run   <= flip ? 0 : run;
            m_sync[0] <= pad;
            for (int i = 1; i < SYNC; i++) m_sync[i] <= m_sync[i-1];
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("model_level", level, m_level);
        check("model_rise",  rise,  m_rise);
        check("model_fall",  fall,  m_fall);
        check("model_event", evt,   m_event);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with pad high in bypass: nothing moves until release.
        tick(3);
        check("rst_level", level, 1'b0);
        check("rst_rise",  rise,  1'b0);
        rst = 0;
        tick(2);
        check("byp_level_e2", level, 1'b0);
        tick(1);
        check("byp_level_e3", level, 1'b1);
        check("byp_rise_e3",  rise,  1'b1);
        tick(1);
        check("byp_rise_gone", rise, 1'b0);
        pad = 0;
        tick(3);
        check("byp_fall", fall, 1'b1);
        tick(1);

        // Debounce latency N=5: level moves SYNC+N = 7 edges after pad change.
        fen = 1; dbc = 16'd5;
        pad = 1;
        tick(6);
        check("deb_level_e6", level, 1'b0);
        tick(1);
        check("deb_level_e7", level, 1'b1);
        check("deb_rise_e7",  rise,  1'b1);
        tick(1);
        check("deb_rise_gone", rise, 1'b0);

        // Glitch of 4 cycles is rejected; a 5-cycle pulse is accepted.
        pad = 0; tick(4); pad = 1;
        tick(10);
        check("glitch_level", level, 1'b1);
        pad = 0; tick(5); pad = 1;
        tick(2);
        check("pulse_level", level, 1'b0);
        tick(10);
        check("pulse_recover", level, 1'b1);

        // Event set coinciding with clear: set wins.
        es = 2'b10;
        pad = 0;
        tick(7);
        check("race_fall", fall, 1'b1);
        check("race_evt_pre", evt, 1'b0);
        clr = 1;
        tick(1);
        check("race_evt_set", evt, 1'b1);
        tick(1);
        clr = 0;
        check("clr_evt", evt, 1'b0);

        // Fall with rise-only selection leaves the flag clear.
        es = 2'b00; pad = 1; tick(12);
        es = 2'b01; pad = 0; tick(12);
        check("es01_level", level, 1'b0);
        check("es01_evt",   evt,   1'b0);

        // Lowering the threshold mid-count updates at the next edge.
        es = 2'b00; dbc = 16'd10;
        pad = 1;
        tick(8);
        check("mid_level_pre", level, 1'b0);
        dbc = 16'd4;
        tick(1);
        check("mid_level_post", level, 1'b1);
        check("mid_rise",       rise,  1'b1);
        dbc = 16'd10;

        // Dropping filter_en mid-count updates at the next edge.
        pad = 0;
        tick(5);
        check("fen_level_pre", level, 1'b1);
        fen = 0;
        tick(1);
        check("fen_level_post", level, 1'b0);

        // Async reset in the middle of a count.
        pad = 1; tick(4);
        check("ar_level_hi", level, 1'b1);
        fen = 1; dbc = 16'd10;
        pad = 0; tick(6);
        #2 rst = 1;
        #1;
        check("ar_level", level, 1'b0);
        check("ar_rise",  rise,  1'b0);
        check("ar_fall",  fall,  1'b0);
        check("ar_evt",   evt,   1'b0);
        tick(2);
        rst = 0;
        pad = 1;
        tick(11);
        check("ar_restart_pre", level, 1'b0);
        tick(1);
        check("ar_restart_post", level, 1'b1);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
